// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port pixel RAM arbiter: scanout reads win, one held write; optional VRAM_ARB_BYPASS_EN
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } port_state_t;

  port_state_t       state;
  port_state_t       state_next;
  logic              hold_full;
  logic              hold_full_next;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              accept;
  logic              rd_p2;
  logic [DATA_W-1:0] read_word;

  // Pick the next memory-port operation: scanout first, then the held write.
  always_comb begin
    state_next     = ST_IDLE;
    accept         = wr_valid && wr_ready;
    hold_full_next = hold_full;
    if (rd_req) begin
      state_next = ST_RD;
    end else if (hold_full) begin
      state_next = ST_WR;
    end
    if (state_next == ST_WR) begin
      hold_full_next = 1'b0;
    end else if (accept) begin
      hold_full_next = 1'b1;
    end
  end

  // Memory-port state register; ST_RD also marks the first read pipeline stage.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered RAM address, write enable and write data.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state_next)
        ST_RD: begin
          mem_addr <= rd_addr;
          mem_we   <= 1'b0;
        end
        ST_WR: begin
          mem_addr  <= hold_addr;
          mem_wdata <= hold_data;
          mem_we    <= 1'b1;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  // One-entry write hold register; wr_ready mirrors the next empty state.
  always_ff @(posedge clk) begin
    if (clr) begin
      hold_full <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      wr_ready  <= 1'b0;
    end else begin
      hold_full <= hold_full_next;
      wr_ready  <= !hold_full_next;
      if (accept) begin
        hold_addr <= wr_addr;
        hold_data <= wr_data;
      end
    end
  end

`ifdef VRAM_ARB_BYPASS_EN
  logic              byp_p1;
  logic              byp_p2;
  logic [DATA_W-1:0] byp_d1;
  logic [DATA_W-1:0] byp_d2;

  // Track reads that hit the pending write so they return the held data instead of RAM.
  always_ff @(posedge clk) begin
    if (clr) begin
      byp_p1 <= 1'b0;
      byp_p2 <= 1'b0;
      byp_d1 <= '0;
      byp_d2 <= '0;
    end else begin
      byp_p1 <= rd_req && hold_full && (rd_addr == hold_addr);
      byp_d1 <= hold_data;
      byp_p2 <= byp_p1;
      byp_d2 <= byp_d1;
    end
  end

  assign read_word = byp_p2 ? byp_d2 : mem_rdata;
`else
  assign read_word = mem_rdata;
`endif

  // Read return: RAM data arrives the cycle after the address, captured one edge later.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_p2    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_p2    <= (state == ST_RD);
      rd_valid <= rd_p2;
      if (rd_p2) begin
        rd_data <= read_word;
      end
    end
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: pixel memory address width.
REQ-002 Parameter DATA_W, default 3: pixel word width (RGB).
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 clr  in  1  synchronous, active-high reset.
REQ-005 rd_req  in  1  display scanout read request; one read per cycle while high.
REQ-006 rd_addr  in  ADDR_W  scanout read address, sampled with rd_req.
REQ-007 rd_valid  out  1  rd_data carries a read result this cycle.
REQ-008 rd_data  out  DATA_W  scanout read data, registered.
REQ-009 wr_valid  in  1  writer offers a pixel write.
REQ-010 wr_ready  out  1  arbiter can accept a write; registered, independent of wr_valid.
REQ-011 wr_addr / wr_data  in  ADDR_W / DATA_W  write address and data, sampled on handshake.
REQ-012 mem_addr  out  ADDR_W  registered address to the single-port synchronous RAM.
REQ-013 mem_we  out  1  registered RAM write enable.
REQ-014 mem_wdata  out  DATA_W  registered RAM write data.
REQ-015 mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr is presented.

Function
REQ-016 One RAM operation per cycle; memory port states are IDLE (mem_we=0, no read tracked), RD and WR, decided at each edge.
REQ-017 Priority: rd_req high at edge k -> RD: mem_addr=rd_addr, mem_we=0 from edge k; scanout is never stalled.
REQ-018 Read latency fixed: request sampled at edge k -> rd_valid=1 with its data from edge k+2 for exactly one cycle; back-to-back requests give back-to-back results in order.
REQ-019 A write is accepted at an edge with wr_valid=1 and wr_ready=1 into a 1-entry hold register (addr, data); hold_full set.
REQ-020 wr_ready = !hold_full; accept and commit never occur at the same edge (max write throughput 1 per 2 cycles).
REQ-021 Commit: hold_full=1 and rd_req=0 at edge k -> WR: mem_we=1, mem_addr=hold_addr, mem_wdata=hold_data for the cycle after edge k; hold_full cleared at edge k.
REQ-022 hold_full=1 and rd_req=1 -> read wins; hold retained unchanged; wr_ready stays 0 until committed.
REQ-023 Neither read nor pending write at edge k -> IDLE: mem_we=0, mem_addr holds its last value.
REQ-024 Write accepted at the same edge as a read of the same address: read returns pre-write RAM contents (write ordered after read).
REQ-025 wr_valid dropping without handshake has no effect; wr_addr/wr_data ignored unless handshake occurs.
REQ-026 rd_valid never asserted in cycles not caused by a sampled rd_req.

Reset
REQ-027 clr=1 at an edge: rd_valid=0, rd_data=0, mem_we=0, mem_addr=0, mem_wdata=0, hold_full=0, read pipeline flushed; state IDLE.
REQ-028 wr_ready=0 while clr is high; 1 from the first edge with clr=0.
REQ-029 clr mid-operation: held write discarded uncommitted; in-flight reads produce no rd_valid.

Configuration
REQ-030 Macro VRAM_ARB_BYPASS_EN defined: read sampled at edge k with hold_full=1 and rd_addr==hold_addr returns hold_data at edge k+2 (read-after-write coherence); RAM data ignored for that read.
REQ-031 Macro undefined: no address compare; such reads return RAM contents (stale until commit).

Verification
REQ-032 Reset, then rd_req=1 with rd_addr 0,1,2 on consecutive edges, RAM preloaded mem[i]=i -> rd_valid high 3 cycles starting 2 edges after first request, rd_data 0,1,2.
REQ-033 rd_req=0, write addr 5 data 3'b101 -> wr_ready 0 next cycle; mem_we=1, mem_addr=5, mem_wdata=5 one cycle after acceptance; wr_ready back to 1.
REQ-034 Write addr 7 accepted, rd_req held high 640 cycles -> mem_we stays 0, wr_ready 0 throughout; commit to addr 7 on the first edge with rd_req=0.
REQ-035 Bypass build: hold addr 9 data 3'b110 pending, rd_addr=9 with RAM mem[9]=0 -> rd_data=3'b110; non-bypass build -> rd_data=0.
REQ-036 Write held and two reads in flight, clr pulsed one cycle -> no rd_valid, no mem_we afterwards, RAM addr unchanged, wr_ready=1 after release.
